inst_fetch_queue: RTL and testbench

- Fetch front end on the instruction side of the unified memory.
- Drives `io_if_mem_instAddr`. Captures the two words returned on `io_mem_id_inst_0/1` (word at addr, word at addr+4, combinational read, same cycle).
- Buffers {pc, inst} pairs in a circular queue and presents up to two in-order instructions per cycle to decode.
- Handles redirects (branch/jump flush) and back-pressure from decode.

---
 rtl/inst_fetch_queue_if.sv | 49 ++++
 rtl/inst_fetch_queue.sv | 114 +++++++++++
 tb/tb_inst_fetch_queue.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch queue bus: memory fetch port, redirect, decode-side dequeue and presented entries.
// With FETCH_QUEUE_PERF_EN defined, the stall and fetch-pair counters are carried as well.
interface inst_fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [63:0]      io_if_mem_instAddr;
  logic [31:0]      io_mem_id_inst_0;
  logic [31:0]      io_mem_id_inst_1;
  logic             io_redirect_valid;
  logic [63:0]      io_redirect_pc;
  logic [1:0]       io_deq_count;
  logic             io_out_valid_0;
  logic             io_out_valid_1;
  logic [31:0]      io_out_inst_0;
  logic [31:0]      io_out_inst_1;
  logic [63:0]      io_out_pc_0;
  logic [63:0]      io_out_pc_1;
  logic [CNT_W-1:0] io_count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0]      io_stall_cycles;
  logic [31:0]      io_fetch_pairs;
`endif

  // The fetch queue itself
  modport master (
    input  io_mem_id_inst_0, io_mem_id_inst_1,
    input  io_redirect_valid, io_redirect_pc, io_deq_count,
`ifdef FETCH_QUEUE_PERF_EN
    output io_stall_cycles, io_fetch_pairs,
`endif
    output io_if_mem_instAddr,
    output io_out_valid_0, io_out_valid_1, io_out_inst_0, io_out_inst_1,
    output io_out_pc_0, io_out_pc_1, io_count
  );

  // Memory and decode side
  modport slave (
    output io_mem_id_inst_0, io_mem_id_inst_1,
    output io_redirect_valid, io_redirect_pc, io_deq_count,
`ifdef FETCH_QUEUE_PERF_EN
    input  io_stall_cycles, io_fetch_pairs,
`endif
    input  io_if_mem_instAddr,
    input  io_out_valid_0, io_out_valid_1, io_out_inst_0, io_out_inst_1,
    input  io_out_pc_0, io_out_pc_1, io_count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: fetches two words per cycle into a circular buffer and presents
// up to two in-order {pc, inst} entries to decode. FETCH_QUEUE_PERF_EN adds perf counters.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_reset,
  inst_fetch_queue_if.master bus
);
  localparam int unsigned    PTR_W     = $clog2(DEPTH);
  localparam int unsigned    CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] SPACE_MAX = CNT_W'(DEPTH - 2);

  logic [63:0]      pc_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [63:0]      ent_pc   [DEPTH];
  logic [31:0]      ent_inst [DEPTH];

  logic             rst_any;
  logic             space_ok;
  logic             fe;
  logic [1:0]       deq_max;
  logic [1:0]       deq_eff;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;

  assign rst_any  = reset | io_reset;
  // Space is judged before this cycle's dequeue, so a dequeue never enables a same-cycle fetch
  assign space_ok = (count_q <= SPACE_MAX);
  assign fe       = ~bus.io_redirect_valid & space_ok;
  assign head_p1  = head_q + PTR_W'(1);
  assign tail_p1  = tail_q + PTR_W'(1);

  // Illegal over-dequeue is clamped to the number of presented entries
  always_comb begin
    deq_max = 2'd2;
    deq_eff = bus.io_deq_count;
    if (count_q < CNT_W'(2)) deq_max = 2'(count_q);
    if (bus.io_deq_count > deq_max) deq_eff = deq_max;
  end

  // Pointers, occupancy and fetch PC; reset beats redirect, redirect beats fetch/dequeue
  always_ff @(posedge clock) begin
    if (rst_any) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.io_redirect_valid) begin
      pc_q    <= bus.io_redirect_pc;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_eff);
      count_q <= count_q + (fe ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(deq_eff);
      if (fe) begin
        tail_q <= tail_q + PTR_W'(2);
        pc_q   <= pc_q + 64'd8;
      end
    end
  end

  // Entry storage needs no reset: unoccupied slots are masked on the outputs
  always_ff @(posedge clock) begin
    if (!rst_any && fe) begin
      ent_pc[tail_q]    <= pc_q;
      ent_inst[tail_q]  <= bus.io_mem_id_inst_0;
      ent_pc[tail_p1]   <= pc_q + 64'd4;
      ent_inst[tail_p1] <= bus.io_mem_id_inst_1;
    end
  end

  assign bus.io_if_mem_instAddr = pc_q;
  assign bus.io_count           = count_q;
  assign bus.io_out_valid_0     = (count_q >= CNT_W'(1));
  assign bus.io_out_valid_1     = (count_q >= CNT_W'(2));
  assign bus.io_out_inst_0      = bus.io_out_valid_0 ? ent_inst[head_q]  : 32'h0;
  assign bus.io_out_pc_0        = bus.io_out_valid_0 ? ent_pc[head_q]    : 64'h0;
  assign bus.io_out_inst_1      = bus.io_out_valid_1 ? ent_inst[head_p1] : 32'h0;
  assign bus.io_out_pc_1        = bus.io_out_valid_1 ? ent_pc[head_p1]   : 64'h0;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] pairs_q;

  // Stalls count only space-limited cycles, never redirect cycles
  always_ff @(posedge clock) begin
    if (rst_any) begin
      stall_q <= '0;
      pairs_q <= '0;
    end else begin
      if (!bus.io_redirect_valid && !space_ok) stall_q <= stall_q + 32'd1;
      if (fe) pairs_q <= pairs_q + 32'd1;
    end
  end

  assign bus.io_stall_cycles = stall_q;
  assign bus.io_fetch_pairs  = pairs_q;
`endif

`ifndef SYNTHESIS
  // Decode must never consume more entries than are presented
  always @(posedge clock) begin
    if (!rst_any && !bus.io_redirect_valid)
      a_deq_legal: assert (bus.io_deq_count <= deq_max);
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized and directed bench for inst_fetch_queue against a queue-based reference model.
// Honours FETCH_QUEUE_PERF_EN to also check the performance counters.
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH    = 8;
  localparam logic [63:0] RESET_PC = 64'h0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clock;
  logic reset;
  logic io_reset;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock    (clock),
    .reset    (reset),
    .io_reset (io_reset),
    .bus      (bus)
  );

  int          n_checks;
  int          n_fail;
  ent_t        mq[$];
  logic [63:0] m_pc;
  logic [31:0] m_stall;
  logic [31:0] m_pairs;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h1000 + 32'(a >> 2);
  endfunction

  // Unified memory: combinational two-word read
  always_comb begin
    bus.io_mem_id_inst_0 = mem_word(bus.io_if_mem_instAddr);
    bus.io_mem_id_inst_1 = mem_word(bus.io_if_mem_instAddr + 64'd4);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_all();
    ent_t e0;
    ent_t e1;
    e0 = '0;
    e1 = '0;
    if (mq.size() >= 1) e0 = mq[0];
    if (mq.size() >= 2) e1 = mq[1];
    check_eq("inst_addr", bus.io_if_mem_instAddr, m_pc);
    check_eq("count",   64'(bus.io_count),       64'(mq.size()));
    check_eq("valid_0", 64'(bus.io_out_valid_0), 64'(mq.size() >= 1));
    check_eq("valid_1", 64'(bus.io_out_valid_1), 64'(mq.size() >= 2));
    check_eq("inst_0",  64'(bus.io_out_inst_0),  64'(e0.inst));
    check_eq("pc_0",    bus.io_out_pc_0,         e0.pc);
    check_eq("inst_1",  64'(bus.io_out_inst_1),  64'(e1.inst));
    check_eq("pc_1",    bus.io_out_pc_1,         e1.pc);
`ifdef FETCH_QUEUE_PERF_EN
    check_eq("stall_cycles", 64'(bus.io_stall_cycles), 64'(m_stall));
    check_eq("fetch_pairs",  64'(bus.io_fetch_pairs),  64'(m_pairs));
`endif
  endtask

  // Reference model: applies one clock of the queue rules to the queue and fetch PC
  task automatic model_update(input logic rst, input logic srst, input logic rv,
                              input logic [63:0] rpc, input logic [1:0] deq);
    bit fe;
    if (rst || srst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_stall = '0;
      m_pairs = '0;
    end else if (rv) begin
      mq.delete();
      m_pc = rpc;
    end else begin
      fe = (int'(DEPTH) - mq.size()) >= 2;
      for (int i = 0; i < int'(deq); i++) void'(mq.pop_front());
      if (fe) begin
        mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
        mq.push_back('{pc: m_pc + 64'd4, inst: mem_word(m_pc + 64'd4)});
        m_pc    = m_pc + 64'd8;
        m_pairs = m_pairs + 32'd1;
      end else begin
        m_stall = m_stall + 32'd1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic srst, input logic rv,
                      input logic [63:0] rpc, input logic [1:0] deq);
    reset                 = rst;
    io_reset              = srst;
    bus.io_redirect_valid = rv;
    bus.io_redirect_pc    = rpc;
    bus.io_deq_count      = deq;
    @(posedge clock);
    model_update(rst, srst, rv, rpc, deq);
    #1;
    check_all();
  endtask

  initial begin
    int hi;
    int r;
    logic [63:0] rpc;
    logic [1:0]  deq;
    n_checks = 0;
    n_fail   = 0;
    m_pc     = RESET_PC;
    m_stall  = '0;
    m_pairs  = '0;

    // Reset release and fill to full
    step(1'b1, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("rst_addr", bus.io_if_mem_instAddr, 64'h0);
    check_eq("rst_valid0", 64'(bus.io_out_valid_0), 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("c1_addr", bus.io_if_mem_instAddr, 64'd8);
    check_eq("c1_inst0", 64'(bus.io_out_inst_0), 64'h1000);
    check_eq("c1_pc0", bus.io_out_pc_0, 64'h0);
    check_eq("c1_inst1", 64'(bus.io_out_inst_1), 64'h1001);
    check_eq("c1_pc1", bus.io_out_pc_1, 64'h4);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("c2_addr", bus.io_if_mem_instAddr, 64'd16);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("full_count", 64'(bus.io_count), 64'd8);
    check_eq("full_addr", bus.io_if_mem_instAddr, 64'd32);

    // Dequeue from full frees space only for the following cycle
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd2);
    check_eq("deq_count", 64'(bus.io_count), 64'd6);
    check_eq("deq_addr", bus.io_if_mem_instAddr, 64'd32);
    check_eq("deq_head_pc", bus.io_out_pc_0, 64'd8);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("resume_count", 64'(bus.io_count), 64'd8);
    check_eq("resume_addr", bus.io_if_mem_instAddr, 64'd40);
    check_eq("resume_head_pc", bus.io_out_pc_0, 64'd8);

    // Steady state across head wrap
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd2);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0, 2'd2);
      check_eq("ss_count", 64'(bus.io_count), 64'd6);
      check_eq("ss_addr", bus.io_if_mem_instAddr, 64'(40 + 8 * k));
      check_eq("ss_head_pc", bus.io_out_pc_0, 64'(16 + 8 * k));
    end

    // Redirect with count=5 and a pending dequeue
    step(1'b1, 1'b0, 1'b0, 64'h0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd1);
    check_eq("pre_redir_count", 64'(bus.io_count), 64'd5);
    step(1'b0, 1'b0, 1'b1, 64'h200, 2'd2);
    check_eq("redir_count", 64'(bus.io_count), 64'd0);
    check_eq("redir_valid1", 64'(bus.io_out_valid_1), 64'h0);
    check_eq("redir_addr", bus.io_if_mem_instAddr, 64'h200);
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("redir_pc0", bus.io_out_pc_0, 64'h200);
    check_eq("redir_pc1", bus.io_out_pc_1, 64'h204);

    // Soft reset beats a simultaneous redirect
    step(1'b0, 1'b0, 1'b0, 64'h0, 2'd1);
    step(1'b0, 1'b1, 1'b1, 64'h400, 2'd0);
    check_eq("srst_addr", bus.io_if_mem_instAddr, RESET_PC);
    check_eq("srst_count", 64'(bus.io_count), 64'd0);

`ifdef FETCH_QUEUE_PERF_EN
    // Ten cycles without dequeue: four fetches, six space stalls; redirect does not count
    step(1'b1, 1'b0, 1'b0, 64'h0, 2'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
    check_eq("perf_pairs", 64'(bus.io_fetch_pairs), 64'd4);
    check_eq("perf_stalls", 64'(bus.io_stall_cycles), 64'd6);
    step(1'b0, 1'b0, 1'b1, 64'h80, 2'd0);
    check_eq("perf_redir_stalls", 64'(bus.io_stall_cycles), 64'd6);
`endif

    // Randomized traffic with redirects, soft resets and misaligned targets
    for (int n = 0; n < 600; n++) begin
      hi  = (mq.size() >= 2) ? 2 : mq.size();
      deq = 2'($urandom_range(hi, 0));
      if ($urandom_range(3, 0) != 0 && hi == 2) deq = 2'd2;
      r   = int'($urandom_range(63, 0));
      rpc = {$urandom, $urandom};
      if ($urandom_range(7, 0) != 0) rpc[1:0] = 2'b00;
      step(1'b0, r == 0, r < 4, rpc, deq);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
